alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_if.sv | 30 +++
 rtl/alu_issue_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bundle: upstream instruction, downstream writeback, ALU operands.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
interface alu_issue_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] instr;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [3:0] wb_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] ctrl;
    logic [1:0] rd;
    logic [7:0] stall_cnt;

    // Environment side: drives instructions, writebacks and the ALU consume strobe
    modport master (
        output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, a, b, ctrl, rd, stall_cnt
    );

    // Issue stage side
    modport slave (
        input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, a, b, ctrl, rd, stall_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: 4x4 register file, busy scoreboard, hazard stall, operand output register.
// Latency: one cycle from accept to out_valid; writeback data bypassed into operand read.
// Backpressure: in_ready drops on hazard or when a held output is not consumed; outputs hold stable.
module alu_issue_stage (
    input  logic                clk,
    input  logic                rst,
    alu_issue_stage_if.slave    io
);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] ctrl;
        logic [1:0] rd;
    } issue_t;

    logic [3:0] rf [4];
    logic [3:0] busy;
    issue_t     out_q;
    issue_t     out_d;
    logic       out_vld_q;
    logic [7:0] stall_q;

    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [1:0] rd_in;
    logic [2:0] ctrl_in;
    logic [3:0] wb_clr;
    logic [3:0] hs_set;
    logic [3:0] busy_eff;
    logic       hz_busy;
    logic       hz_out;
    logic       hz;
    logic       in_rdy;
    logic       accept;
    logic       out_hs;
    logic [3:0] op_a;
    logic [3:0] op_b;

    // Instruction field decode
    always_comb begin
        ctrl_in = io.instr[8:6];
        rd_in   = io.instr[5:4];
        rs1     = io.instr[3:2];
        rs2     = io.instr[1:0];
    end

    // Hazard detection and handshake qualification; a same-cycle writeback
    // releases its register immediately, while the pending output entry
    // always blocks readers of its rd (its result cannot exist yet)
    always_comb begin
        wb_clr   = io.wb_en ? (4'b0001 << io.wb_addr) : 4'b0000;
        out_hs   = out_vld_q & io.out_ready;
        hs_set   = out_hs ? (4'b0001 << out_q.rd) : 4'b0000;
        busy_eff = busy & ~wb_clr;
        hz_busy  = busy_eff[rs1] | busy_eff[rs2];
        hz_out   = out_vld_q & ((out_q.rd == rs1) | (out_q.rd == rs2));
        hz       = hz_busy | hz_out;
        in_rdy   = ~hz & (~out_vld_q | io.out_ready);
        accept   = io.in_valid & in_rdy;
    end

    // Operand read with writeback bypass, independently per operand
    always_comb begin
        op_a = (io.wb_en && (io.wb_addr == rs1)) ? io.wb_data : rf[rs1];
        op_b = (io.wb_en && (io.wb_addr == rs2)) ? io.wb_data : rf[rs2];
        out_d.a    = op_a;
        out_d.b    = op_b;
        out_d.ctrl = ctrl_in;
        out_d.rd   = rd_in;
    end

    // Register file write from the writeback port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= 4'b0000;
            end
        end else if (io.wb_en) begin
            rf[io.wb_addr] <= io.wb_data;
        end
    end

    // Scoreboard: clear on writeback, then set on output handshake so set wins
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 4'b0000;
        end else begin
            busy <= (busy & ~wb_clr) | hs_set;
        end
    end

    // Output register: load on accept, drop valid once consumed, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_vld_q <= 1'b1;
            out_q     <= out_d;
        end else if (out_hs) begin
            out_vld_q <= 1'b0;
        end
    end

    // Saturating count of cycles an offered instruction was refused
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 8'h00;
        end else if (io.in_valid && !in_rdy && (stall_q != 8'hFF)) begin
            stall_q <= stall_q + 8'd1;
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.out_valid = out_vld_q;
    assign io.a         = out_q.a;
    assign io.b         = out_q.b;
    assign io.ctrl      = out_q.ctrl;
    assign io.rd        = out_q.rd;
    assign io.stall_cnt = stall_q;

endmodule
